eeprom_slave: RTL and testbench
===============================

# eeprom_slave

Synthesizable two-wire EEPROM responder: a 2048 x 8 memory behind a serial control/address/data protocol, answering device code 1010 with the 3 high address bits carried in the control byte. It is the far end of the EEPROM write/read master on the SCL/SDA pair. It lets that master be exercised in simulation and on an FPGA without a physical 24C16 part. SCL and SDA are oversampled on CLK; no logic is clocked by SCL.

## Interface

Parameters:
- DEV_ID, 4'b1010, device code matched against control byte bits [7:4]
- MEM_DEPTH, 2048, bytes of storage; address is 11 bits

Ports:
- CLK  input  1  system clock; SCL high and low phases each ≥ 4 CLK periods
- RESET  input  1  asynchronous, active-low reset
- SCL  input  1  serial clock from master
- SDA  inout  1  serial data; driven only to 1'b0, otherwise 1'bz (open drain, external pull-up)
- BUSY  output  1  high from detected START to detected STOP
- WR_STB  output  1  one-CLK pulse when a byte is committed to memory
- WR_ADDR  output  11  address of the byte committed on WR_STB

## Operation

- SCL and SDA each pass through a 2-flop synchronizer, then a third register for edge detection.
- Bus conditions are evaluated on synchronized values:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Bits are sampled on SCL rise; SDA drive changes only after SCL fall.
- START in any state: clear bit counter, go to CTRL, set BUSY. This covers repeated START.
- STOP in any state: release SDA, go to IDLE, clear BUSY. A partial byte is discarded.
- State machine, with 8 data bits per byte, MSB first:
  - IDLE: wait for START.
  - CTRL: shift 8 bits.
    - If [7:4] == DEV_ID: latch [3:1] as addr[10:8], latch [0] as RW, go to CTRL_ACK.
    - Otherwise go to IDLE; SDA stays released and BUSY stays high until STOP.
  - CTRL_ACK: drive SDA low for the 9th clock.
    - RW=0: go to ADDR.
    - RW=1: go to RDATA, loading the shift register with mem[addr].
  - ADDR: shift 8 bits into addr[7:0], then go to ADDR_ACK (ACK), then WDATA.
  - WDATA: shift 8 bits.
    - On the 8th rising edge write mem[addr] and pulse WR_STB with WR_ADDR = addr.
    - Go to WDATA_ACK (ACK); after the ACK clock, increment addr and return to WDATA.
  - RDATA: drive shift-register MSB (0 → drive low, 1 → release) for 8 clocks, then release SDA.
  - RDATA_ACK: sample the master bit on the 9th rising edge.
    - 0: increment addr, load mem[addr], go to RDATA.
    - 1 (NACK): go to IDLE and wait for STOP/START.
- Read address increment is always linear, 11-bit, 2047 → 0 wraps.
- A write followed by a repeated START with RW=1 reads from the address just set: the random-read sequence.
- Memory contents are not affected by reset.

## Timing

- Reset values: SDA = z, BUSY = 0, WR_STB = 0, WR_ADDR = 0, state IDLE, addr = 0.
- Edge detection latency: 3 CLK from pin change to internal event.
- Write commit: WR_STB asserts 1 CLK after the internal 8th SCL-rise event of a data byte. Exactly one pulse per byte.
- ACK drive: SDA goes low 1 CLK after the internal SCL-fall event that ends bit 8. It releases 1 CLK after the internal SCL-fall event that ends bit 9.
- Read data: each bit is presented 1 CLK after the internal SCL-fall event, and held through the following SCL high.
- Simultaneous START/STOP detection and bit sampling cannot occur: they require SDA to change while SCL is high. START/STOP take priority over any shift.
- RESET asserted mid-transfer: SDA is released immediately (asynchronously) and the state machine goes to IDLE.

## Configuration

- EEPROM_PAGE_WRAP_EN defined: the write-address increment affects only addr[3:0]. Writes wrap within a 16-byte page (e.g. 0x00F → 0x000); addr[10:4] is unchanged.
- Not defined: the write increment is linear over 11 bits, 0x7FF → 0x000.
- Reads are linear in both builds.

## Test plan

- Single write: START, 0xA2, 0x34, 0x5A, STOP.
  - ACK on all three bytes.
  - WR_STB once with WR_ADDR = 0x134.
  - mem[0x134] = 0x5A.
- Random read of the same location: START, 0xA2, 0x34, repeated START, 0xA3, read 1 byte, NACK, STOP.
  - SDA carries 0x5A.
  - BUSY falls 3 CLK after STOP.
- Multi-byte write at 0x7FE with 0x11, 0x22, 0x33:
  - Linear build: writes to 0x7FE, 0x7FF, 0x000.
  - EEPROM_PAGE_WRAP_EN build: writes to 0x7FE, 0x7FF, 0x7F0.
- Sequential read from 0x7FF with master ACK: two bytes returned, from mem[0x7FF] then mem[0x000].
- Wrong device code, control byte 0x92: no ACK (SDA z on the 9th clock), no WR_STB, no SDA drive until the next START.
- RESET low during the 4th bit of a data byte: SDA becomes z in the same cycle and there is no WR_STB. After release, a fresh write transaction succeeds.

Source files
------------

// File: rtl/eeprom_slave.sv
// eeprom_slave: two-wire 2048 x 8 EEPROM responder; SCL/SDA are oversampled on CLK.
// Build option EEPROM_PAGE_WRAP_EN: write-address increment wraps inside a 16-byte page.
module eeprom_slave #(
    parameter logic [3:0] DEV_ID    = 4'b1010,
    parameter int         MEM_DEPTH = 2048
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SCL,
    inout  wire         SDA,
    output logic        BUSY,
    output logic        WR_STB,
    output logic [10:0] WR_ADDR,
    output logic [3:0]  STATE_DBG
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CTRL      = 4'd1,
        ST_CTRL_ACK  = 4'd2,
        ST_ADDR      = 4'd3,
        ST_ADDR_ACK  = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  scl_r, sda_r;
    logic [7:0]  sr;
    logic [2:0]  bit_cnt;
    logic [10:0] addr;
    logic        rw;
    logic        sda_low, sda_low_nx;
    logic [7:0]  mem [0:MEM_DEPTH-1];

    // Idle bus is high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            scl_r <= 3'b111;
            sda_r <= 3'b111;
        end else begin
            scl_r <= {scl_r[1:0], SCL};
            sda_r <= {sda_r[1:0], SDA};
        end
    end

    logic scl_s, scl_d, sda_s, sda_d;
    assign scl_s = scl_r[1];
    assign scl_d = scl_r[2];
    assign sda_s = sda_r[1];
    assign sda_d = sda_r[2];

    logic scl_rise, scl_fall, start_ev, stop_ev, last_bit;
    logic [7:0]  sr_in;
    logic [10:0] addr_wr_inc, addr_rd_inc;
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;
    assign last_bit = (bit_cnt == 3'd7);
    assign sr_in    = {sr[6:0], sda_s};
    assign addr_rd_inc = addr + 11'd1;
`ifdef EEPROM_PAGE_WRAP_EN
    assign addr_wr_inc = {addr[10:4], addr[3:0] + 4'd1};
`else
    assign addr_wr_inc = addr + 11'd1;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start_ev) begin
            state_nx = ST_CTRL;
        end else if (stop_ev) begin
            state_nx = ST_IDLE;
        end else if (scl_rise) begin
            case (state)
                ST_CTRL:      if (last_bit) state_nx = (sr_in[7:4] == DEV_ID) ? ST_CTRL_ACK : ST_IDLE;
                ST_CTRL_ACK:  state_nx = rw ? ST_RDATA : ST_ADDR;
                ST_ADDR:      if (last_bit) state_nx = ST_ADDR_ACK;
                ST_ADDR_ACK:  state_nx = ST_WDATA;
                ST_WDATA:     if (last_bit) state_nx = ST_WDATA_ACK;
                ST_WDATA_ACK: state_nx = ST_WDATA;
                ST_RDATA:     if (last_bit) state_nx = ST_RDATA_ACK;
                ST_RDATA_ACK: state_nx = sda_s ? ST_IDLE : ST_RDATA;
                default:      state_nx = ST_IDLE;
            endcase
        end
    end

    // Level SDA takes after the next SCL fall; the state has already advanced on the rise before it.
    always_comb begin
        sda_low_nx = 1'b0;
        case (state)
            ST_CTRL_ACK, ST_ADDR_ACK, ST_WDATA_ACK: sda_low_nx = 1'b1;
            ST_RDATA:                               sda_low_nx = ~sr[7];
            default:                                sda_low_nx = 1'b0;
        endcase
    end

    assign SDA       = sda_low ? 1'b0 : 1'bz;
    assign STATE_DBG = state;

    // WR_STB is a single-cycle strobe; WR_ADDR is valid while it is high and holds until the next one.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sr      <= 8'h00;
            bit_cnt <= 3'd0;
            addr    <= 11'h000;
            rw      <= 1'b0;
            sda_low <= 1'b0;
            BUSY    <= 1'b0;
            WR_STB  <= 1'b0;
            WR_ADDR <= 11'h000;
        end else begin
            WR_STB <= 1'b0;
            if (start_ev) begin
                bit_cnt <= 3'd0;
                BUSY    <= 1'b1;
                sda_low <= 1'b0;
            end else if (stop_ev) begin
                bit_cnt <= 3'd0;
                BUSY    <= 1'b0;
                sda_low <= 1'b0;
            end else if (scl_fall) begin
                sda_low <= sda_low_nx;
            end else if (scl_rise) begin
                case (state)
                    ST_CTRL, ST_ADDR, ST_WDATA: begin
                        sr      <= sr_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit && state == ST_CTRL && sr_in[7:4] == DEV_ID) begin
                            addr[10:8] <= sr_in[3:1];
                            rw         <= sr_in[0];
                        end
                        if (last_bit && state == ST_ADDR) addr[7:0] <= sr_in;
                        if (last_bit && state == ST_WDATA) begin
                            WR_STB  <= 1'b1;
                            WR_ADDR <= addr;
                        end
                    end
                    ST_CTRL_ACK: begin
                        bit_cnt <= 3'd0;
                        if (rw) sr <= mem[addr];
                    end
                    ST_ADDR_ACK: bit_cnt <= 3'd0;
                    ST_WDATA_ACK: begin
                        bit_cnt <= 3'd0;
                        addr    <= addr_wr_inc;
                    end
                    ST_RDATA: begin
                        sr      <= {sr[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ST_RDATA_ACK: begin
                        bit_cnt <= 3'd0;
                        if (!sda_s) begin
                            addr <= addr_rd_inc;
                            sr   <= mem[addr_rd_inc];
                        end
                    end
                    default: bit_cnt <= 3'd0;
                endcase
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (scl_rise && !start_ev && !stop_ev && state == ST_WDATA && last_bit)
            mem[addr] <= sr_in;
    end

endmodule

// File: tb/tb_eeprom_slave.sv
// Directed bench for eeprom_slave: bus-level master tasks, WR_ADDR scoreboard, final report.
module tb_eeprom_slave;
    localparam int Q = 8;
`ifdef EEPROM_PAGE_WRAP_EN
    localparam logic [10:0] THIRD_ADDR = 11'h7F0;
    localparam logic [7:0]  MEM0_EXP   = 8'h77;
`else
    localparam logic [10:0] THIRD_ADDR = 11'h000;
    localparam logic [7:0]  MEM0_EXP   = 8'h33;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic scl = 1'b1;
    logic m_low = 1'b0;
    wire  sda;
    wire  busy, wr_stb;
    wire  [10:0] wr_addr;
    wire  [3:0]  state_dbg;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup pu_sda (sda);

    always #5 clk = ~clk;

    eeprom_slave dut (
        .CLK(clk), .RESET(reset_n), .SCL(scl), .SDA(sda),
        .BUSY(busy), .WR_STB(wr_stb), .WR_ADDR(wr_addr), .STATE_DBG(state_dbg)
    );

    int total = 0;
    int bad = 0;
    logic [10:0] exp_q[$];
    logic [10:0] got_q[$];
    int   drive_viol = 0;
    logic mon_nodrive = 1'b0;

    always @(negedge clk) begin
        if (wr_stb) got_q.push_back(wr_addr);
        if (mon_nodrive && !m_low && sda === 1'b0) drive_viol++;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start;
        m_low = 1'b0; clks(Q/2); scl = 1'b1; clks(Q);
        m_low = 1'b1; clks(Q); scl = 1'b0;
    endtask

    task automatic bus_stop;
        clks(Q/2); m_low = 1'b1; clks(Q/2); scl = 1'b1; clks(Q);
        m_low = 1'b0; clks(Q);
    endtask

    task automatic write_bit(input logic b);
        clks(Q/2); m_low = ~b; clks(Q/2); scl = 1'b1; clks(Q); scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        clks(Q/2); m_low = 1'b0; clks(Q/2); scl = 1'b1; clks(Q/2);
        b = (sda === 1'b0) ? 1'b0 : 1'b1;
        clks(Q/2); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack_n);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack_n);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; clks(3);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (wr_stb !== 1'b0) begin bad++; $display("FAIL reset_wr_stb got=%0b want=0", wr_stb); end
        total++; if (wr_addr !== 11'h000) begin bad++; $display("FAIL reset_wr_addr got=%h want=000", wr_addr); end
        total++; if (sda !== 1'b1) begin bad++; $display("FAIL reset_sda got=%b want=1", sda); end
        total++; if (state_dbg !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
        reset_n = 1'b1; clks(Q);
    endtask

    task automatic test_single_write;
        logic a0, a1, a2;
        exp_q.delete(); got_q.delete();
        exp_q.push_back(11'h134);
        bus_start;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy_high got=%0b want=1", busy); end
        send_byte(8'hA2, a0); send_byte(8'h34, a1); send_byte(8'h5A, a2);
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL wr_acks got=%b want=000", {a0, a1, a2}); end
        bus_stop; clks(4);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_low got=%0b want=0", busy); end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL wr_strobe_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end else for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL wr_addr[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_read;
        logic a0, a1, a2;
        logic [7:0] d;
        got_q.delete();
        bus_start; send_byte(8'hA2, a0); send_byte(8'h34, a1);
        bus_start; send_byte(8'hA3, a2);
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL rd_acks got=%b want=000", {a0, a1, a2}); end
        recv_byte(d, 1'b1);
        total++; if (d !== 8'h5A) begin bad++; $display("FAIL rd_data got=%h want=5a", d); end
        clks(Q/2); m_low = 1'b1; clks(Q/2); scl = 1'b1; clks(Q);
        m_low = 1'b0;
        clks(2);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stop_busy_2clk got=%0b want=1", busy); end
        clks(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy_3clk got=%0b want=0", busy); end
        clks(Q);
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL rd_no_strobe got=%0d want=0", got_q.size()); end
    endtask

    task automatic test_multi_write;
        logic [3:0] acks;
        logic [5:0] macks;
        logic [2:0] racks;
        logic [7:0] c;
        logic [7:0] d;
        exp_q.delete(); got_q.delete();
        bus_start; send_byte(8'hA0, acks[0]); send_byte(8'h00, acks[1]); send_byte(8'h77, acks[2]); bus_stop;
        exp_q.push_back(11'h000);
        bus_start; send_byte(8'hAE, macks[0]); send_byte(8'hFE, macks[1]);
        send_byte(8'h11, macks[2]); send_byte(8'h22, macks[3]); send_byte(8'h33, macks[4]);
        bus_stop;
        macks[5] = acks[0] | acks[1] | acks[2];
        exp_q.push_back(11'h7FE); exp_q.push_back(11'h7FF); exp_q.push_back(THIRD_ADDR);
        total++; if (macks !== 6'b0) begin bad++; $display("FAIL multi_acks got=%b want=000000", macks); end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL multi_strobe_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end else for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL multi_addr[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        c = {4'b1010, THIRD_ADDR[10:8], 1'b0};
        bus_start; send_byte(c, racks[0]); send_byte(THIRD_ADDR[7:0], racks[1]);
        bus_start; send_byte(c | 8'h01, racks[2]);
        recv_byte(d, 1'b1); bus_stop;
        total++; if (racks !== 3'b000) begin bad++; $display("FAIL multi_rd_acks got=%b want=000", racks); end
        total++; if (d !== 8'h33) begin bad++; $display("FAIL multi_third_data got=%h want=33", d); end
    endtask

    task automatic test_seq_read;
        logic [2:0] racks;
        logic [7:0] d0, d1;
        bus_start; send_byte(8'hAE, racks[0]); send_byte(8'hFF, racks[1]);
        bus_start; send_byte(8'hAF, racks[2]);
        recv_byte(d0, 1'b0); recv_byte(d1, 1'b1); bus_stop;
        total++; if (racks !== 3'b000) begin bad++; $display("FAIL seq_acks got=%b want=000", racks); end
        total++; if (d0 !== 8'h22) begin bad++; $display("FAIL seq_byte0 got=%h want=22", d0); end
        total++; if (d1 !== MEM0_EXP) begin bad++; $display("FAIL seq_byte1 got=%h want=%h", d1, MEM0_EXP); end
    endtask

    task automatic test_wrong_device;
        logic a0, a1;
        got_q.delete(); drive_viol = 0; mon_nodrive = 1'b1;
        bus_start; send_byte(8'h92, a0); send_byte(8'h5A, a1);
        total++; if ({a0, a1} !== 2'b11) begin bad++; $display("FAIL wrong_dev_ack got=%b want=11", {a0, a1}); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wrong_dev_busy got=%0b want=1", busy); end
        bus_stop; clks(4); mon_nodrive = 1'b0;
        total++; if (drive_viol != 0) begin bad++; $display("FAIL wrong_dev_drive got=%0d want=0", drive_viol); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrong_dev_busy_end got=%0b want=0", busy); end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL wrong_dev_strobe got=%0d want=0", got_q.size()); end
    endtask

    task automatic test_reset_mid;
        logic a0, a1, a2, a3, a4;
        logic [7:0] d;
        got_q.delete(); exp_q.delete();
        bus_start; send_byte(8'hA0, a0); send_byte(8'h10, a1);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        clks(Q/2); m_low = 1'b0; clks(Q/2); scl = 1'b1; clks(Q/2);
        reset_n = 1'b0; #1;
        total++; if (state_dbg !== 4'd0) begin bad++; $display("FAIL rst_mid_state got=%0d want=0", state_dbg); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%0b want=0", busy); end
        clks(Q/2); scl = 1'b0; clks(Q); reset_n = 1'b1;
        for (int i = 0; i < 4; i++) write_bit(1'b0);
        read_bit(a2);
        clks(Q/2); m_low = 1'b0; scl = 1'b1; clks(2*Q);
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL rst_mid_strobe got=%0d want=0", got_q.size()); end
        bus_start;
        for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 5);
        clks(Q/2); m_low = 1'b0; clks(Q/2); scl = 1'b1; clks(Q/2);
        total++; if (sda !== 1'b0) begin bad++; $display("FAIL rst_ack_driven got=%b want=0", sda); end
        reset_n = 1'b0; #1;
        total++; if (sda !== 1'b1) begin bad++; $display("FAIL rst_ack_release got=%b want=1", sda); end
        clks(Q); scl = 1'b0; clks(Q); scl = 1'b1; clks(Q); reset_n = 1'b1; clks(Q);
        exp_q.push_back(11'h010);
        bus_start; send_byte(8'hA0, a0); send_byte(8'h10, a1); send_byte(8'h55, a2); bus_stop;
        bus_start; send_byte(8'hA0, a3); send_byte(8'h10, a4);
        bus_start; send_byte(8'hA1, a2);
        recv_byte(d, 1'b1); bus_stop;
        total++; if ({a0, a1, a2, a3, a4} !== 5'b0) begin bad++; $display("FAIL rst_fresh_acks got=%b want=00000", {a0, a1, a2, a3, a4}); end
        total++; if (d !== 8'h55) begin bad++; $display("FAIL rst_fresh_data got=%h want=55", d); end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL rst_fresh_strobe_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end else for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rst_fresh_addr[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_random_read;
        test_multi_write;
        test_seq_read;
        test_wrong_device;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
